// File: rtl/reg_dump_scanner.sv
// Register-file dump engine: walks indices 0..NUM_REGS-1 and presents each value on a
// valid/ready stream. Define REG_DUMP_SKIP_ZERO_EN to drop registers that read as zero.
module reg_dump_scanner #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Abort,
    output logic [4:0]            Read_Reg,
    input  logic [DATA_WIDTH-1:0] Read_Data,
    output logic [4:0]            Out_Index,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Busy,
    output logic                  Done
);

    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StHold, StFin} state_e;

    state_e                  state_q, state_d;
    logic [4:0]              idx_q, idx_d;
    logic [4:0]              index_q, index_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
                if (Read_Data == '0) begin
                    if (idx_q == LastIdx) state_d = StFin;
                    else                  idx_d   = idx_q + 5'd1;
                end else begin
                    data_d  = Read_Data;
                    index_d = idx_q;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
`else
                data_d  = Read_Data;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = StHold;
`endif
            end
            StHold: begin
                if (valid_q && Out_Ready) begin
                    valid_d = 1'b0;
                    // idx parks on the last index rather than wrapping
                    if (idx_q == LastIdx) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StScan;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (Abort && (state_q != StIdle)) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end
    end

    assign Read_Reg  = idx_q;
    assign Out_Index = index_q;
    assign Out_Data  = data_q;
    assign Out_Valid = valid_q;
    assign Busy      = (state_q != StIdle);
    assign Done      = (state_q == StFin);

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Self-checking bench for reg_dump_scanner: a register-file array plus a queue-based model of
// the expected entry stream and its cycle timing.
module tb_reg_dump_scanner;

    localparam int NumRegs = 32;
`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SkipZero = 1'b1;
`else
    localparam bit SkipZero = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [4:0]  Read_Reg;
    logic [31:0] Read_Data;
    logic [4:0]  Out_Index;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready = 1'b1;
    logic        Busy;
    logic        Done;

    logic [31:0] regs [NumRegs];
    int checks = 0;
    int errors = 0;

    assign Read_Data = regs[Read_Reg];

    always #5 Clock = ~Clock;

    reg_dump_scanner #(.NUM_REGS(NumRegs), .DATA_WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Abort     (Abort),
        .Read_Reg  (Read_Reg),
        .Read_Data (Read_Data),
        .Out_Index (Out_Index),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(Out_Valid), 64'd0);
        check({tag, "_busy"},  64'(Busy),      64'd0);
        check({tag, "_done"},  64'(Done),      64'd0);
    endtask

    // Runs one dump from Start to Done, comparing every accepted entry with the model queue.
    task automatic run_dump(input bit rand_ready, input int stall_idx, input bit poke_start,
                            input bit write3);
        logic [4:0]  q_idx[$];
        logic [31:0] q_dat[$];
        logic [4:0]  h_idx;
        logic [31:0] h_dat;
        int  cyc = 0, last_acc = 0, last_idx = -1, stall_left = 5, hold_cnt = 0;
        bit  done_seen = 0, wrote = 0, held = 0, was_held;
        for (int i = 0; i < NumRegs; i++) begin
            if (!(SkipZero && regs[i] == 32'd0)) begin
                q_idx.push_back(5'(i));
                q_dat.push_back(regs[i]);
            end
        end
        @(negedge Clock); Start = 1'b1; Out_Ready = 1'b1;
        @(negedge Clock); Start = 1'b0; cyc = 1;
        while (!done_seen && cyc < 400) begin
            @(negedge Clock);
            cyc++;
            Start = poke_start && (cyc == 10);
            was_held = held;
            held = 0;
            if (was_held) begin
                check("hold_valid", 64'(Out_Valid), 64'd1);
                check("hold_index", 64'(Out_Index), 64'(h_idx));
                check("hold_data",  64'(Out_Data),  64'(h_dat));
            end
            // Negedge write landing just before reg 3 is captured
            if (write3 && !wrote && Busy && !Out_Valid && Read_Reg == 5'd3) begin
                regs[3] = 32'hCAFE_0003;
                foreach (q_idx[k]) if (q_idx[k] == 5'd3) q_dat[k] = 32'hCAFE_0003;
                wrote = 1;
            end
            if (Done) begin
                check("done_queue_empty", 64'(q_idx.size()), 64'd0);
                if (last_idx >= 0)
                    check("done_time", 64'(cyc), 64'(last_acc + 1 + (NumRegs - 1 - last_idx)));
                done_seen = 1;
            end else if (Out_Valid) begin
                if (int'(Out_Index) == stall_idx) hold_cnt++;
                if (!was_held)
                    check("valid_time", 64'(cyc), 64'(last_acc + (int'(Out_Index) - last_idx) + 1));
                if (int'(Out_Index) == stall_idx && stall_left > 0) begin
                    Out_Ready = 1'b0;
                    stall_left--;
                end else begin
                    Out_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (Out_Ready) begin
                    check("entry_available", 64'(q_idx.size() != 0), 64'd1);
                    if (q_idx.size() != 0) begin
                        check("entry_index", 64'(Out_Index), 64'(q_idx.pop_front()));
                        check("entry_data",  64'(Out_Data),  64'(q_dat.pop_front()));
                    end
                    last_acc = cyc;
                    last_idx = int'(Out_Index);
                end else begin
                    held  = 1;
                    h_idx = Out_Index;
                    h_dat = Out_Data;
                end
            end else begin
                Out_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        Start = 1'b0;
        check("dump_completed", 64'(done_seen), 64'd1);
        if (write3) check("reg3_written", 64'(wrote), 64'd1);
        if (stall_idx >= 0) check("stall_hold_cycles", 64'(hold_cnt), 64'd6);
        @(negedge Clock);
        check("done_one_cycle", 64'(Done), 64'd0);
        check("busy_after_done", 64'(Busy), 64'd0);
    endtask

    task automatic fill_random(input int zero_pct);
        for (int i = 0; i < NumRegs; i++) begin
            regs[i] = ($urandom_range(0, 99) < zero_pct) ? 32'd0 : ($urandom | 32'd1);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NumRegs; i++) regs[i] = 32'(i * 3);

        // Reset state
        #1;
        check_idle_outputs("reset");
        check("reset_index", 64'(Out_Index), 64'd0);
        check("reset_data",  64'(Out_Data),  64'd0);
        check("reset_rdreg", 64'(Read_Reg),  64'd0);
        @(negedge Clock); Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("no_autostart", 64'(Busy), 64'd0);

        // Full dump, ready tied high, reg i = i*3
        run_dump(1'b0, -1, 1'b0, 1'b0);

        // Consumer stalls 5 cycles on reg 7
        fill_random(0);
        regs[7] = 32'h0000_1234;
        run_dump(1'b0, 7, 1'b0, 1'b0);

        // Random data with some zeros, random backpressure
        fill_random(25);
        run_dump(1'b1, -1, 1'b0, 1'b0);

        // Negedge write to reg 3 just before its capture
        fill_random(0);
        regs[3] = 32'h0BAD_0001;
        run_dump(1'b0, -1, 1'b0, 1'b1);

        // Abort while holding reg 12
        fill_random(0);
        found = 0;
        @(negedge Clock); Start = 1'b1; Out_Ready = 1'b1;
        @(negedge Clock); Start = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge Clock);
            if (Out_Valid && Out_Index == 5'd12) begin
                Abort = 1'b1;
                found = 1;
            end
        end
        check("abort_reached_12", 64'(found), 64'd1);
        @(negedge Clock); Abort = 1'b0;
        check_idle_outputs("abort");
        repeat (3) begin
            @(negedge Clock);
            check_idle_outputs("post_abort");
        end
        run_dump(1'b0, -1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges, mid-dump
        fill_random(0);
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (6) @(negedge Clock);
        check("pre_reset_busy", 64'(Busy), 64'd1);
        #2 Reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_index", 64'(Out_Index), 64'd0);
        check("async_reset_data",  64'(Out_Data),  64'd0);
        check("async_reset_rdreg", 64'(Read_Reg),  64'd0);
        #1 Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check_idle_outputs("post_reset");
        end
        // Start pulsed while busy must not restart the walk
        run_dump(1'b0, -1, 1'b1, 1'b0);

        // Mostly-zero file: only regs 29 and 31 nonzero
        for (int i = 0; i < NumRegs; i++) regs[i] = 32'd0;
        regs[29] = 32'h0000_1FFF;
        regs[31] = 32'd5;
        run_dump(1'b0, -1, 1'b0, 1'b0);

        // Start and Abort together in IDLE: Start wins; Abort alone in IDLE does nothing
        @(negedge Clock); Start = 1'b1; Abort = 1'b1;
        @(negedge Clock); Start = 1'b0; Abort = 1'b0;
        check("start_beats_abort", 64'(Busy), 64'd1);
        check("restart_rdreg", 64'(Read_Reg), 64'd0);
        Abort = 1'b1;
        @(negedge Clock); Abort = 1'b0;
        check_idle_outputs("abort_in_scan");
        Abort = 1'b1;
        @(negedge Clock); Abort = 1'b0;
        check_idle_outputs("abort_in_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
